// File: rtl/key_rate_selector.sv
// key_rate_selector
//   Front end of the LED blinker. Conditions the raw active-low push button
//   (2-flop synchroniser + debounce FSM), classifies each accepted press as
//   short or long, and keeps a 4-entry blink-rate selection. A short press
//   advances the rate (wrapping 3 -> 0). A long press returns it to rate 0.
//   PERIOD is the half-period terminal count for the selected rate.
//
// Ports
//   CLOCK_50      in   system clock, all logic on its rising edge
//   reset         in   asynchronous, active-high; clears all state
//   KEY_N         in   raw push button, active-low, asynchronous to CLOCK_50
//   RATE_SEL      out  [1:0]  current rate index
//   PERIOD        out  [25:0] half-period terminal count for RATE_SEL
//   PERIOD_VALID  out  one-cycle pulse when PERIOD changes
//   KEY_PRESS     out  one-cycle pulse when a debounced press is accepted
//   LONG_PRESS    out  one-cycle pulse when a hold is classified as long
module key_rate_selector #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000,
  parameter int P0              = 50000000,
  parameter int P1              = 25000000,
  parameter int P2              = 12500000,
  parameter int P3              = 6250000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        KEY_N,
  output logic [1:0]  RATE_SEL,
  output logic [25:0] PERIOD,
  output logic        PERIOD_VALID,
  output logic        KEY_PRESS,
  output logic        LONG_PRESS
);

  localparam int MAX_CYCLES = (LONG_CYCLES > DEBOUNCE_CYCLES) ? LONG_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    HELD,
    RELEASE_WAIT
  } state_t;

  function automatic logic [25:0] period_lut(input logic [1:0] idx);
    case (idx)
      2'd0:    period_lut = 26'(P0);
      2'd1:    period_lut = 26'(P1);
      2'd2:    period_lut = 26'(P2);
      default: period_lut = 26'(P3);
    endcase
  endfunction

  logic             key_p0;
  logic             key_p1;
  logic             key_s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] hold;
  logic [CNT_W-1:0] hold_nxt;
  logic [CNT_W-1:0] hold_inc;
  logic [1:0]       rate_nxt;
  logic             key_press_nxt;
  logic             long_press_nxt;
  logic             period_valid_nxt;

  // stage p0/p1: synchroniser on the inverted (active-high) key
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      key_p0 <= 1'b0;
      key_p1 <= 1'b0;
    end else begin
      key_p0 <= ~KEY_N;
      key_p1 <= key_p0;
    end
  end

  assign key_s    = key_p1;
  assign cnt_inc  = cnt + CNT_W'(1);
  assign hold_inc = hold + CNT_W'(1);

  // Debounce / classification next-state logic. A press is accepted once the
  // incremented count reaches DEBOUNCE_CYCLES-1, so the IDLE sample plus the
  // PRESS_WAIT samples total DEBOUNCE_CYCLES stable cycles.
  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    hold_nxt         = hold;
    rate_nxt         = RATE_SEL;
    key_press_nxt    = 1'b0;
    long_press_nxt   = 1'b0;
    period_valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (key_s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!key_s) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == DEB_LAST) begin
            state_nxt     = PRESSED;
            key_press_nxt = 1'b1;
            hold_nxt      = '0;
          end
        end
      end
      PRESSED: begin
        if (key_s) begin
          hold_nxt = hold_inc;
          if (hold_inc == LONG_LAST) begin
            state_nxt        = HELD;
            long_press_nxt   = 1'b1;
            rate_nxt         = 2'd0;
            // Only announce a period change if the rate actually moves.
            period_valid_nxt = (RATE_SEL != 2'd0);
          end
        end else begin
          // Short press: 2-bit add wraps 3 -> 0 naturally.
          rate_nxt         = RATE_SEL + 2'd1;
          period_valid_nxt = 1'b1;
          state_nxt        = RELEASE_WAIT;
          cnt_nxt          = '0;
        end
      end
      HELD: begin
        if (!key_s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (key_s) begin
          // Release bounce restarts the quiet-time count; no new press.
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == DEB_LAST) begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        hold_nxt  = '0;
      end
    endcase
  end

  // stage p2: FSM state, counters and registered outputs. PERIOD is loaded
  // from the same rate_nxt as RATE_SEL so the two never disagree.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      hold         <= '0;
      RATE_SEL     <= 2'd0;
      PERIOD       <= 26'(P0);
      PERIOD_VALID <= 1'b0;
      KEY_PRESS    <= 1'b0;
      LONG_PRESS   <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      hold         <= hold_nxt;
      RATE_SEL     <= rate_nxt;
      PERIOD       <= period_lut(rate_nxt);
      PERIOD_VALID <= period_valid_nxt;
      KEY_PRESS    <= key_press_nxt;
      LONG_PRESS   <= long_press_nxt;
    end
  end

endmodule

// File: tb/tb_key_rate_selector.sv
// tb_key_rate_selector
//   Directed bench for key_rate_selector with DEBOUNCE_CYCLES=4,
//   LONG_CYCLES=20 and half-periods 40/20/10/5. Inputs change 1 time unit
//   after a rising edge; outputs are observed on the falling edge.
module tb_key_rate_selector;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b0;
  logic        KEY_N    = 1'b1;
  logic [1:0]  RATE_SEL;
  logic [25:0] PERIOD;
  logic        PERIOD_VALID;
  logic        KEY_PRESS;
  logic        LONG_PRESS;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  int kp_cnt, lp_cnt, pv_cnt;
  int kp_cyc, lp_cyc, pv_cyc;
  logic [1:0]  rate_q[$];
  logic [25:0] per_q[$];

  key_rate_selector #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .P0             (40),
    .P1             (20),
    .P2             (10),
    .P3             (5)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .KEY_N       (KEY_N),
    .RATE_SEL    (RATE_SEL),
    .PERIOD      (PERIOD),
    .PERIOD_VALID(PERIOD_VALID),
    .KEY_PRESS   (KEY_PRESS),
    .LONG_PRESS  (LONG_PRESS)
  );

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  function automatic logic [25:0] exp_period(input logic [1:0] r);
    case (r)
      2'd0:    exp_period = 26'd40;
      2'd1:    exp_period = 26'd20;
      2'd2:    exp_period = 26'd10;
      default: exp_period = 26'd5;
    endcase
  endfunction

  // Per-cycle observer: period/rate agreement, pulse exclusivity, and a
  // record of every pulse for the scenario tasks.
  always @(negedge CLOCK_50) begin
    if (mon_en) begin
      n_cmp++;
      if (PERIOD !== exp_period(RATE_SEL)) begin
        n_fail++;
        $display("FAIL period_track cyc=%0d rate=%0d period=%0d required=%0d",
                 cyc, RATE_SEL, PERIOD, exp_period(RATE_SEL));
      end
      n_cmp++;
      if ((int'(KEY_PRESS) + int'(LONG_PRESS) + int'(PERIOD_VALID)) > 1 &&
          !(LONG_PRESS && PERIOD_VALID && !KEY_PRESS)) begin
        n_fail++;
        $display("FAIL pulse_exclusive cyc=%0d kp=%0b lp=%0b pv=%0b required at most one",
                 cyc, KEY_PRESS, LONG_PRESS, PERIOD_VALID);
      end
      if (KEY_PRESS === 1'b1) begin
        kp_cnt++;
        kp_cyc = cyc;
      end
      if (LONG_PRESS === 1'b1) begin
        lp_cnt++;
        lp_cyc = cyc;
      end
      if (PERIOD_VALID === 1'b1) begin
        pv_cnt++;
        pv_cyc = cyc;
        rate_q.push_back(RATE_SEL);
        per_q.push_back(PERIOD);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic clear_mon();
    kp_cnt = 0; lp_cnt = 0; pv_cnt = 0;
    kp_cyc = -1; lp_cyc = -1; pv_cyc = -1;
    rate_q.delete();
    per_q.delete();
  endtask

  // Entered 1 unit after a rising edge; asserts and releases reset mid-cycle.
  task automatic do_reset();
    #4;
    reset = 1'b1;
    @(posedge CLOCK_50);
    #3;
    reset = 1'b0;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic short_press(output int fall, output int rise);
    KEY_N = 1'b0;
    fall  = cyc;
    tick(10);
    KEY_N = 1'b1;
    rise  = cyc;
    tick(16);
  endtask

  task automatic test_reset();
    tick(2);
    #4;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (RATE_SEL !== 2'd0) begin n_fail++; $display("FAIL reset_rate got=%0d required=0", RATE_SEL); end
    n_cmp++;
    if (PERIOD !== 26'd40) begin n_fail++; $display("FAIL reset_period got=%0d required=40", PERIOD); end
    n_cmp++;
    if ({KEY_PRESS, LONG_PRESS, PERIOD_VALID} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses got=%b required=000", {KEY_PRESS, LONG_PRESS, PERIOD_VALID});
    end
    @(posedge CLOCK_50);
    #3;
    reset = 1'b0;
    tick(1);
    clear_mon();
    mon_en = 1'b1;
    tick(50);
    n_cmp++;
    if (kp_cnt + lp_cnt + pv_cnt !== 0) begin
      n_fail++; $display("FAIL idle_pulses got=%0d required=0", kp_cnt + lp_cnt + pv_cnt);
    end
    n_cmp++;
    if (RATE_SEL !== 2'd0 || PERIOD !== 26'd40) begin
      n_fail++; $display("FAIL idle_state rate=%0d period=%0d required 0/40", RATE_SEL, PERIOD);
    end
  endtask

  task automatic test_short_press();
    int fall, rise;
    do_reset();
    clear_mon();
    short_press(fall, rise);
    n_cmp++;
    if (kp_cnt !== 1) begin n_fail++; $display("FAIL short_kp_count got=%0d required=1", kp_cnt); end
    n_cmp++;
    if (kp_cyc - fall !== 6) begin n_fail++; $display("FAIL short_kp_latency got=%0d required=6", kp_cyc - fall); end
    n_cmp++;
    if (pv_cnt !== 1) begin n_fail++; $display("FAIL short_pv_count got=%0d required=1", pv_cnt); end
    n_cmp++;
    if (pv_cyc - rise !== 3) begin n_fail++; $display("FAIL short_pv_latency got=%0d required=3", pv_cyc - rise); end
    n_cmp++;
    if (RATE_SEL !== 2'd1 || PERIOD !== 26'd20) begin
      n_fail++; $display("FAIL short_result rate=%0d period=%0d required 1/20", RATE_SEL, PERIOD);
    end
    n_cmp++;
    if (lp_cnt !== 0) begin n_fail++; $display("FAIL short_lp_count got=%0d required=0", lp_cnt); end
  endtask

  task automatic test_bounce();
    do_reset();
    clear_mon();
    for (int i = 0; i < 5; i++) begin
      KEY_N = 1'b0;
      tick(2);
      KEY_N = 1'b1;
      tick(1);
    end
    tick(20);
    n_cmp++;
    if (kp_cnt !== 0) begin n_fail++; $display("FAIL bounce_kp_count got=%0d required=0", kp_cnt); end
    n_cmp++;
    if (RATE_SEL !== 2'd0 || pv_cnt !== 0) begin
      n_fail++; $display("FAIL bounce_rate rate=%0d pv=%0d required 0/0", RATE_SEL, pv_cnt);
    end
  endtask

  task automatic test_wrap();
    int fall, rise;
    logic [1:0]  exp_r [4];
    logic [25:0] exp_p [4];
    exp_r[0] = 2'd1; exp_r[1] = 2'd2; exp_r[2] = 2'd3; exp_r[3] = 2'd0;
    exp_p[0] = 26'd20; exp_p[1] = 26'd10; exp_p[2] = 26'd5; exp_p[3] = 26'd40;
    do_reset();
    clear_mon();
    for (int i = 0; i < 4; i++) short_press(fall, rise);
    n_cmp++;
    if (pv_cnt !== 4 || kp_cnt !== 4) begin
      n_fail++; $display("FAIL wrap_counts pv=%0d kp=%0d required 4/4", pv_cnt, kp_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < rate_q.size()) begin
        n_cmp++;
        if (rate_q[i] !== exp_r[i] || per_q[i] !== exp_p[i]) begin
          n_fail++;
          $display("FAIL wrap_step%0d rate=%0d period=%0d required %0d/%0d",
                   i, rate_q[i], per_q[i], exp_r[i], exp_p[i]);
        end
      end
    end
  endtask

  task automatic test_long_press();
    int fall, rise;
    do_reset();
    short_press(fall, rise);
    short_press(fall, rise);
    n_cmp++;
    if (RATE_SEL !== 2'd2) begin n_fail++; $display("FAIL long_setup rate=%0d required=2", RATE_SEL); end
    clear_mon();
    KEY_N = 1'b0;
    fall  = cyc;
    tick(40);
    KEY_N = 1'b1;
    tick(20);
    n_cmp++;
    if (kp_cnt !== 1 || lp_cnt !== 1 || pv_cnt !== 1) begin
      n_fail++; $display("FAIL long_counts kp=%0d lp=%0d pv=%0d required 1/1/1", kp_cnt, lp_cnt, pv_cnt);
    end
    n_cmp++;
    if (lp_cyc - fall !== 25) begin n_fail++; $display("FAIL long_latency got=%0d required=25", lp_cyc - fall); end
    n_cmp++;
    if (pv_cyc !== lp_cyc) begin n_fail++; $display("FAIL long_pv_cycle got=%0d required=%0d", pv_cyc, lp_cyc); end
    n_cmp++;
    if (RATE_SEL !== 2'd0 || PERIOD !== 26'd40) begin
      n_fail++; $display("FAIL long_result rate=%0d period=%0d required 0/40", RATE_SEL, PERIOD);
    end
  endtask

  task automatic test_release_bounce();
    int fall, rise;
    do_reset();
    clear_mon();
    KEY_N = 1'b0;
    tick(10);
    KEY_N = 1'b1;
    tick(4);
    KEY_N = 1'b0;
    tick(1);
    KEY_N = 1'b1;
    tick(20);
    n_cmp++;
    if (kp_cnt !== 1 || pv_cnt !== 1) begin
      n_fail++; $display("FAIL relbounce_counts kp=%0d pv=%0d required 1/1", kp_cnt, pv_cnt);
    end
    n_cmp++;
    if (RATE_SEL !== 2'd1) begin n_fail++; $display("FAIL relbounce_rate got=%0d required=1", RATE_SEL); end
    short_press(fall, rise);
    n_cmp++;
    if (kp_cnt !== 2 || RATE_SEL !== 2'd2) begin
      n_fail++; $display("FAIL relbounce_next kp=%0d rate=%0d required 2/2", kp_cnt, RATE_SEL);
    end
  endtask

  task automatic test_reset_mid_hold();
    int fall, rise, rel;
    do_reset();
    short_press(fall, rise);
    clear_mon();
    KEY_N = 1'b0;
    tick(8);
    #4;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (RATE_SEL !== 2'd0 || PERIOD !== 26'd40) begin
      n_fail++; $display("FAIL midhold_reset rate=%0d period=%0d required 0/40", RATE_SEL, PERIOD);
    end
    n_cmp++;
    if ({KEY_PRESS, LONG_PRESS, PERIOD_VALID} !== 3'b000) begin
      n_fail++; $display("FAIL midhold_pulses got=%b required=000", {KEY_PRESS, LONG_PRESS, PERIOD_VALID});
    end
    clear_mon();
    @(posedge CLOCK_50);
    #3;
    reset = 1'b0;
    rel   = cyc;
    tick(10);
    n_cmp++;
    if (kp_cnt !== 1 || kp_cyc - rel !== 6) begin
      n_fail++; $display("FAIL held_after_reset kp=%0d latency=%0d required 1/6", kp_cnt, kp_cyc - rel);
    end
    n_cmp++;
    if (lp_cnt !== 0 || pv_cnt !== 0) begin
      n_fail++; $display("FAIL held_after_reset_pulses lp=%0d pv=%0d required 0/0", lp_cnt, pv_cnt);
    end
    KEY_N = 1'b1;
    tick(15);
    n_cmp++;
    if (RATE_SEL !== 2'd1 || PERIOD !== 26'd20) begin
      n_fail++; $display("FAIL held_after_reset_rate rate=%0d period=%0d required 1/20", RATE_SEL, PERIOD);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_short_press();
    test_bounce();
    test_wrap();
    test_long_press();
    test_release_bounce();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
